osd_cmd_tx: RTL and testbench

FPGA-side transmitter for the OSD command port: turns a single command request plus an optional byte stream into the `io_osd` / `io_strobe` / `io_din` framing that the OSD overlay consumes. It lets on-chip logic enable or disable the OSD, and fill OSD buffer lines, without the HPS. Typical uses are a fabric-side menu renderer or a boot splash. It sits in the `clk_sys` domain and drives the OSD port directly, or through a mux with the HPS I/O path.

---
 rtl/osd_cmd_tx.sv | 123 ++++++++++++
 tb/tb_osd_cmd_tx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_cmd_tx.sv
// Fabric-side transmitter for the OSD command port: frames one command byte plus an
// optional data stream onto io_osd / io_strobe / io_din.
`timescale 1ns/1ps
module osd_cmd_tx #(
  parameter int unsigned STROBE_HI = 1,
  parameter int unsigned STROBE_LO = 1,
  parameter int unsigned GAP       = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [4:0]  cmd_arg,
  input  logic [12:0] cmd_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        io_osd,
  output logic        io_strobe,
  output logic [15:0] io_din,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_CHI   = 3'd2;
  localparam logic [2:0] S_CLO   = 3'd3;
  localparam logic [2:0] S_DWAIT = 3'd4;
  localparam logic [2:0] S_DHI   = 3'd5;
  localparam logic [2:0] S_DLO   = 3'd6;
  localparam logic [2:0] S_GAPW  = 3'd7;

  // Timer reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [7:0] HI_LOAD  = 8'(STROBE_HI - 1);
  localparam logic [7:0] LO_LOAD  = 8'(STROBE_LO - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);

  logic [2:0]  state_reg;
  logic        op_reg;
  logic [12:0] rem_reg;
  logic [7:0]  timer_reg;
  logic [7:0]  cmd_byte;

  assign cmd_byte  = cmd_op ? {3'b001, cmd_arg} : {7'b0100000, cmd_arg[0]};
  assign cmd_ready = (state_reg == S_IDLE);
  assign wr_ready  = (state_reg == S_DWAIT);
  assign busy      = (state_reg != S_IDLE);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      op_reg    <= 1'b0;
      rem_reg   <= '0;
      timer_reg <= '0;
      io_osd    <= 1'b0;
      io_strobe <= 1'b0;
      io_din    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            op_reg    <= cmd_op;
            rem_reg   <= cmd_op ? cmd_len : 13'd0;
            io_osd    <= 1'b1;
            io_strobe <= 1'b0;
            io_din    <= {8'h00, cmd_byte};
            state_reg <= S_SETUP;
          end
        end
        S_SETUP: begin
          io_strobe <= 1'b1;
          timer_reg <= HI_LOAD;
          state_reg <= S_CHI;
        end
        S_CHI, S_DHI: begin
          if (timer_reg == 8'd0) begin
            io_strobe <= 1'b0;
            timer_reg <= LO_LOAD;
            state_reg <= (state_reg == S_CHI) ? S_CLO : S_DLO;
          end else begin
            timer_reg <= timer_reg - 8'd1;
          end
        end
        S_CLO, S_DLO: begin
          if (timer_reg != 8'd0) begin
            timer_reg <= timer_reg - 8'd1;
          end else if (rem_reg != 13'd0 && (op_reg || state_reg == S_DLO)) begin
            state_reg <= S_DWAIT;
          end else begin
            // Falling io_osd is what commits the command at the receiver.
            io_osd    <= 1'b0;
            io_din    <= '0;
            timer_reg <= GAP_LOAD;
            state_reg <= S_GAPW;
          end
        end
        S_DWAIT: begin
          if (wr_valid) begin
            io_din    <= {8'h00, wr_data};
            io_strobe <= 1'b1;
            rem_reg   <= rem_reg - 13'd1;
            timer_reg <= HI_LOAD;
            state_reg <= S_DHI;
          end
        end
        S_GAPW: begin
          if (timer_reg == 8'd0) begin
            done      <= 1'b1;
            state_reg <= S_IDLE;
          end else begin
            timer_reg <= timer_reg - 8'd1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_cmd_tx.sv
// Scoreboard bench for osd_cmd_tx: one instance with default timing, one stretched
// (HI=3, LO=2, GAP=4). Expected port events are queued at issue time, popped by a monitor.
`timescale 1ns/1ps
module tb_osd_cmd_tx;

  typedef struct {
    byte unsigned kind;
    int           val;
    int           cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    int         stall;
  } src_t;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset     [2];
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic        cmd_op    [2];
  logic [4:0]  cmd_arg   [2];
  logic [12:0] cmd_len   [2];
  logic        wr_ready  [2];
  logic        io_osd    [2];
  logic        io_strobe [2];
  logic [15:0] io_din    [2];
  logic        busy      [2];
  logic        done      [2];

  ev_t  exp_q [2][$];
  src_t src_q [2][$];

  int n_tests = 0;
  int n_fail  = 0;
  bit end_req = 1'b0;
  bit end_ack = 1'b0;

  int hi_exp [2] = '{1, 3};
  int lo_min [2] = '{1, 2};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic       wr_valid;
      logic [7:0] wr_data;

      osd_cmd_tx #(
        .STROBE_HI(gi == 0 ? 1 : 3),
        .STROBE_LO(gi == 0 ? 1 : 2),
        .GAP      (gi == 0 ? 2 : 4)
      ) u_dut (
        .clk_sys  (clk_sys),
        .reset    (reset[gi]),
        .cmd_valid(cmd_valid[gi]),
        .cmd_ready(cmd_ready[gi]),
        .cmd_op   (cmd_op[gi]),
        .cmd_arg  (cmd_arg[gi]),
        .cmd_len  (cmd_len[gi]),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready[gi]),
        .io_osd   (io_osd[gi]),
        .io_strobe(io_strobe[gi]),
        .io_din   (io_din[gi]),
        .busy     (busy[gi]),
        .done     (done[gi])
      );

      // Byte source: presents each queued byte, optionally withholding it for a
      // number of cycles in which the DUT is actually waiting (wr_ready high).
      initial begin : src_proc
        src_t e;
        int   st;
        bit   acc;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        forever begin
          if (src_q[gi].size() == 0) begin
            wr_valid = 1'b0;
            @(posedge clk_sys); #1;
          end else begin
            e = src_q[gi].pop_front();
            st = e.stall;
            wr_valid = 1'b0;
            while (st > 0) begin
              @(negedge clk_sys);
              if (wr_ready[gi]) st--;
              @(posedge clk_sys); #1;
            end
            wr_valid = 1'b1;
            wr_data  = e.data;
            acc = 1'b0;
            while (!acc) begin
              @(negedge clk_sys);
              acc = wr_ready[gi];
              @(posedge clk_sys); #1;
            end
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------- monitor
  int          cyc      [2];
  logic        osd_p    [2];
  logic        st_p     [2];
  logic        wrr_p    [2];
  logic        rst_p    [2];
  int          hi_cnt   [2];
  int          lo_cnt   [2];
  int          low_run  [2];
  bit          lo_valid [2];
  bit          low_seen [2];
  bit          din_chg  [2];
  logic [15:0] din_rise [2];

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d, required %0d", name, k, act, exp);
    end
  endtask

  task automatic take_ev(input int k, input byte unsigned kind, input int val);
    ev_t e;
    n_tests++;
    if (exp_q[k].size() == 0) begin
      n_fail++;
      $display("FAIL event dut%0d: got %c val=%0h cyc=%0d, required no event", k, kind, val, cyc[k]);
    end else begin
      e = exp_q[k].pop_front();
      if (e.kind != kind || (e.val != -1 && e.val != val) || e.cyc != cyc[k]) begin
        n_fail++;
        $display("FAIL event dut%0d: got %c val=%0h cyc=%0d, required %c val=%0h cyc=%0d",
                 k, kind, val, cyc[k], e.kind, e.val, e.cyc);
      end else begin
        $display("[TB] dut%0d event %c val=%0h cycle %0d", k, kind, val, cyc[k]);
      end
    end
  endtask

  always @(negedge clk_sys) begin
    for (int k = 0; k < 2; k++) begin
      if (reset[k]) begin
        chk("rst_ctrl", k, int'({io_osd[k], io_strobe[k], done[k], busy[k]}), 0);
        chk("rst_din", k, int'(io_din[k]), 0);
        cyc[k]      = 1000;
        hi_cnt[k]   = 0;
        lo_valid[k] = 1'b0;
        low_seen[k] = 1'b0;
      end else begin
        if (rst_p[k]) chk("ready_after_rst", k, int'(cmd_ready[k]), 1);
        cyc[k]++;
        if (done[k]) take_ev(k, "D", int'(cmd_ready[k]));
        if (io_osd[k] && !osd_p[k]) take_ev(k, "O", low_seen[k] ? low_run[k] : -1);
        if (!io_osd[k] && osd_p[k]) take_ev(k, "F", int'(io_din[k]));
        if (wr_ready[k] && !wrr_p[k]) take_ev(k, "R", int'({io_osd[k], io_strobe[k], busy[k]}));
        if (io_strobe[k] && !st_p[k]) begin
          take_ev(k, "W", int'(io_din[k]));
          if (lo_valid[k]) chk("lo_min", k, int'(lo_cnt[k] >= lo_min[k]), 1);
          hi_cnt[k]   = 1;
          din_rise[k] = io_din[k];
          din_chg[k]  = 1'b0;
        end else if (io_strobe[k]) begin
          hi_cnt[k]++;
          if (io_din[k] != din_rise[k]) din_chg[k] = 1'b1;
        end
        if (!io_strobe[k] && st_p[k]) begin
          chk("hi_len", k, hi_cnt[k], hi_exp[k]);
          chk("din_stable", k, int'(din_chg[k]), 0);
          lo_cnt[k]   = 1;
          lo_valid[k] = 1'b1;
        end else if (!io_strobe[k]) begin
          lo_cnt[k]++;
        end
        if (!io_osd[k]) lo_valid[k] = 1'b0;
        if (!io_osd[k] && osd_p[k]) begin
          low_run[k]  = 1;
          low_seen[k] = 1'b1;
        end else if (!io_osd[k]) begin
          low_run[k]++;
        end
        if (wr_ready[k]) chk("dwait_hold", k, int'({io_osd[k], io_strobe[k]}), 2);
        if (cmd_valid[k] && cmd_ready[k]) cyc[k] = 0;
      end
      osd_p[k] = io_osd[k];
      st_p[k]  = io_strobe[k];
      wrr_p[k] = wr_ready[k];
      rst_p[k] = reset[k];
    end
    if (end_req && !end_ack) begin
      chk("queue_empty", 0, exp_q[0].size() + exp_q[1].size(), 0);
      end_ack = 1'b1;
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic push_ev(input int k, input byte unsigned kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    exp_q[k].push_back(e);
  endtask

  task automatic push_src(input int k, input logic [7:0] d, input int stall);
    src_t s;
    s.data  = d;
    s.stall = stall;
    src_q[k].push_back(s);
  endtask

  // Called just after a rising edge; the current cycle becomes cycle 0.
  task automatic issue(input int k, input logic op, input logic [4:0] arg, input logic [12:0] len);
    cmd_op[k]    = op;
    cmd_arg[k]   = arg;
    cmd_len[k]   = len;
    cmd_valid[k] = 1'b1;
    @(posedge clk_sys); #1;
    cmd_valid[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk_sys);
      if (done[k]) break;
    end
    @(posedge clk_sys); #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset[k]     = 1'b1;
      cmd_valid[k] = 1'b0;
      cmd_op[k]    = 1'b0;
      cmd_arg[k]   = 5'd0;
      cmd_len[k]   = 13'd0;
    end
    repeat (3) @(posedge clk_sys);
    #1;
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    // Enable, arg 1 -> 0x41
    push_ev(0, "O", -1, 1); push_ev(0, "W", 'h41, 2); push_ev(0, "F", 0, 4); push_ev(0, "D", 1, 6);
    issue(0, 1'b0, 5'h01, 13'd0);
    wait_done(0, 60);

    // Highres buffer write, three bytes, source always valid
    push_src(0, 8'hA5, 0); push_src(0, 8'h5A, 0); push_src(0, 8'hFF, 0);
    push_ev(0, "O", -1, 1); push_ev(0, "W", 'h28, 2);
    push_ev(0, "R", 5, 4);  push_ev(0, "W", 'hA5, 5);
    push_ev(0, "R", 5, 7);  push_ev(0, "W", 'h5A, 8);
    push_ev(0, "R", 5, 10); push_ev(0, "W", 'hFF, 11);
    push_ev(0, "F", 0, 13); push_ev(0, "D", 1, 15);
    issue(0, 1'b1, 5'h08, 13'd3);
    wait_done(0, 60);

    // Same write with a 20-cycle source stall before the second byte
    push_src(0, 8'hA5, 0); push_src(0, 8'h5A, 20); push_src(0, 8'hFF, 0);
    push_ev(0, "O", -1, 1); push_ev(0, "W", 'h28, 2);
    push_ev(0, "R", 5, 4);  push_ev(0, "W", 'hA5, 5);
    push_ev(0, "R", 5, 7);  push_ev(0, "W", 'h5A, 28);
    push_ev(0, "R", 5, 30); push_ev(0, "W", 'hFF, 31);
    push_ev(0, "F", 0, 33); push_ev(0, "D", 1, 35);
    issue(0, 1'b1, 5'h08, 13'd3);
    wait_done(0, 100);

    // Zero-length write: command byte only
    push_ev(0, "O", -1, 1); push_ev(0, "W", 'h25, 2); push_ev(0, "F", 0, 4); push_ev(0, "D", 1, 6);
    issue(0, 1'b1, 5'h05, 13'd0);
    wait_done(0, 60);

    // Disable: only arg bit 0 matters -> 0x40; cmd_len ignored
    push_ev(0, "O", -1, 1); push_ev(0, "W", 'h40, 2); push_ev(0, "F", 0, 4); push_ev(0, "D", 1, 6);
    issue(0, 1'b0, 5'h1E, 13'd7);
    wait_done(0, 60);

    // Reset during DHI of byte 2 (cycle 8), then a clean enable frame
    push_src(0, 8'h11, 0); push_src(0, 8'h22, 0); push_src(0, 8'h33, 0);
    push_ev(0, "O", -1, 1); push_ev(0, "W", 'h30, 2);
    push_ev(0, "R", 5, 4);  push_ev(0, "W", 'h11, 5);
    push_ev(0, "R", 5, 7);
    issue(0, 1'b1, 5'h10, 13'd3);
    repeat (7) @(posedge clk_sys);
    #1;
    reset[0] = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    reset[0] = 1'b0;
    push_ev(0, "O", -1, 1); push_ev(0, "W", 'h41, 2); push_ev(0, "F", 0, 4); push_ev(0, "D", 1, 6);
    issue(0, 1'b0, 5'h01, 13'd0);
    wait_done(0, 60);

    // Stretched instance: 1-byte write, then back-to-back enable accepted in the done cycle
    push_src(1, 8'h7E, 0);
    push_ev(1, "O", -1, 1); push_ev(1, "W", 'h22, 2);
    push_ev(1, "R", 5, 7);  push_ev(1, "W", 'h7E, 8);
    push_ev(1, "F", 0, 13); push_ev(1, "D", 1, 17);
    push_ev(1, "O", 5, 1);  push_ev(1, "W", 'h41, 2);
    push_ev(1, "F", 0, 7);  push_ev(1, "D", 1, 11);
    cmd_op[1]    = 1'b1;
    cmd_arg[1]   = 5'h02;
    cmd_len[1]   = 13'd1;
    cmd_valid[1] = 1'b1;
    @(posedge clk_sys); #1;
    cmd_op[1]  = 1'b0;
    cmd_arg[1] = 5'h01;
    cmd_len[1] = 13'd0;
    wait_done(1, 100);
    cmd_valid[1] = 1'b0;
    wait_done(1, 100);

    end_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_sys);
      if (end_ack) break;
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion within 100000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
